// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush and memory-stall hold. Optional perf counters: HAZARD_PERF_CNT_EN.
module id_ex_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               id_memtoreg,
    input  logic               id_alusrc,
    input  logic               id_branch,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [XLEN-1:0]    id_pc,
    input  logic               ex_flush,
    input  logic               mem_stall,
    output logic               ex_valid,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ex_memtoreg,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_pc,
    output logic               load_use_stall,
    output logic               pc_write,
    output logic               ifid_write
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        perf_bubbles,
    output logic [31:0]        perf_freeze
`endif
);

    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic               valid;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               alusrc;
        logic               branch;
        logic [ALUOP_W-1:0] aluop;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
    } ex_regs_t;

    ex_regs_t q;
    ex_regs_t d;
    logic     insert_bubble;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use_stall = id_valid & q.valid & q.memread & (q.rd != REG_W'(0)) &
                         ((id_uses_rs1 & (q.rd == id_rs1)) |
                          (id_uses_rs2 & (q.rd == id_rs2)));
    end

    // A flush outranks the load-use stall: the stalled instruction is being killed anyway
    always_comb begin
        pc_write      = ~mem_stall & (ex_flush | ~load_use_stall);
        ifid_write    = pc_write;
        insert_bubble = ~mem_stall & (ex_flush | load_use_stall);
    end

    always_comb begin
        d = q;
        if (mem_stall) begin
            d = q;
        end else if (insert_bubble) begin
            d = '0;
        end else begin
            d.valid    = id_valid;
            d.rs1      = id_rs1;
            d.rs2      = id_rs2;
            d.rd       = id_rd;
            d.regwrite = id_valid & id_regwrite;
            d.memread  = id_valid & id_memread;
            d.memwrite = id_valid & id_memwrite;
            d.memtoreg = id_valid & id_memtoreg;
            d.alusrc   = id_valid & id_alusrc;
            d.branch   = id_valid & id_branch;
            d.aluop    = id_valid ? id_aluop : ALUOP_W'(0);
            d.rs1_data = id_rs1_data;
            d.rs2_data = id_rs2_data;
            d.imm      = id_imm;
            d.pc       = id_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    always_comb begin
        ex_valid    = q.valid;
        ex_rs1      = q.rs1;
        ex_rs2      = q.rs2;
        ex_rd       = q.rd;
        ex_regwrite = q.regwrite;
        ex_memread  = q.memread;
        ex_memwrite = q.memwrite;
        ex_memtoreg = q.memtoreg;
        ex_alusrc   = q.alusrc;
        ex_branch   = q.branch;
        ex_aluop    = q.aluop;
        ex_rs1_data = q.rs1_data;
        ex_rs2_data = q.rs2_data;
        ex_imm      = q.imm;
        ex_pc       = q.pc;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters for bubbles and memory freezes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubbles <= '0;
            perf_freeze  <= '0;
        end else begin
            if (insert_bubble && (perf_bubbles != '1)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
            if (mem_stall && (perf_freeze != '1)) begin
                perf_freeze <= perf_freeze + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, normal flow, load-use,
// false-stall cases, flush priority and memory freeze.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch;
    logic [3:0]  id_aluop;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        ex_flush, mem_stall;
    logic        ex_valid;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch;
    logic [3:0]  ex_aluop;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic        load_use_stall, pc_write, ifid_write;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_bubbles, perf_freeze;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_branch(id_branch),
        .id_aluop(id_aluop), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .ex_flush(ex_flush), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
        .ex_aluop(ex_aluop), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .load_use_stall(load_use_stall),
        .pc_write(pc_write), .ifid_write(ifid_write)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_bubbles(perf_bubbles), .perf_freeze(perf_freeze)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one decoded instruction into the ID slot
    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic rw, input logic mr, input logic br,
                         input logic [31:0] pc);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = 1'b0;
        id_memtoreg = mr;
        id_alusrc   = mr;
        id_branch   = br;
        id_aluop    = 4'h2;
        id_rs1_data = 32'h1000 + pc;
        id_rs2_data = 32'h2000 + pc;
        id_imm      = pc + 32'h10;
        id_pc       = pc;
    endtask

    initial begin
        rst_n     = 1'b0;
        ex_flush  = 1'b0;
        mem_stall = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd1);
        check("rst_ifid_write", 32'(ifid_write), 32'd1);
        check("rst_load_use", 32'(load_use_stall), 32'd0);

        // Load a regwrite instruction, then reset mid-cycle
        step();
        rst_n = 1'b1;
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
        step();
        check("pre_rst_regwrite", 32'(ex_regwrite), 32'd1);
        check("pre_rst_rd", 32'(ex_rd), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_regwrite", 32'(ex_regwrite), 32'd0);
        check("async_rst_valid", 32'(ex_valid), 32'd0);
        check("async_rst_rd", 32'(ex_rd), 32'd0);
        check("async_rst_pc", ex_pc, 32'd0);
        check("async_rst_pc_write", 32'(pc_write), 32'd1);
        #1 rst_n = 1'b1;

        // Normal flow: four independent instructions
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd10, 5'd11, 5'(i + 1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'(4 * i));
            #1;
            check("flow_pc_write", 32'(pc_write), 32'd1);
            step();
            check("flow_ex_pc", ex_pc, 32'(4 * i));
            check("flow_ex_valid", 32'(ex_valid), 32'd1);
            check("flow_ex_rd", 32'(ex_rd), 32'(i + 1));
        end
        check("flow_ex_imm", ex_imm, 32'h1c);

        // Load-use: lw x5 then add reading x5 via rs2
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20);
        step();
        check("lw_ex_memread", 32'(ex_memread), 32'd1);
        check("lw_ex_rd", 32'(ex_rd), 32'd5);
        drive(1'b1, 5'd7, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h24);
        #1;
        check("lu_stall", 32'(load_use_stall), 32'd1);
        check("lu_pc_write", 32'(pc_write), 32'd0);
        check("lu_ifid_write", 32'(ifid_write), 32'd0);
        step();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_regwrite", 32'(ex_regwrite), 32'd0);
        check("lu_bubble_memread", 32'(ex_memread), 32'd0);
        check("lu_bubble_rd", 32'(ex_rd), 32'd0);
        check("lu_release_stall", 32'(load_use_stall), 32'd0);
        check("lu_release_pc_write", 32'(pc_write), 32'd1);
        step();
        check("lu_add_pc", ex_pc, 32'h24);
        check("lu_add_valid", 32'(ex_valid), 32'd1);
        check("lu_add_rd", 32'(ex_rd), 32'd6);

        // No false stall: rs2 matches but is not used
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h30);
        step();
        drive(1'b1, 5'd1, 5'd5, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h34);
        #1;
        check("nouse_stall", 32'(load_use_stall), 32'd0);
        check("nouse_pc_write", 32'(pc_write), 32'd1);
        step();
        check("nouse_ex_pc", ex_pc, 32'h34);
        check("nouse_ex_valid", 32'(ex_valid), 32'd1);

        // No false stall: load with rd=0
        drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h38);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3c);
        #1;
        check("rd0_stall", 32'(load_use_stall), 32'd0);
        step();
        check("rd0_ex_pc", ex_pc, 32'h3c);

        // Flush and load-use together: flush wins, fetch keeps going
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
        step();
        drive(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h44);
        ex_flush = 1'b1;
        #1;
        check("fl_lu_stall", 32'(load_use_stall), 32'd1);
        check("fl_lu_pc_write", 32'(pc_write), 32'd1);
        check("fl_lu_ifid_write", 32'(ifid_write), 32'd1);
        step();
        ex_flush = 1'b0;
        check("fl_bubble_valid", 32'(ex_valid), 32'd0);
        check("fl_bubble_memread", 32'(ex_memread), 32'd0);
        check("fl_bubble_pc", ex_pc, 32'd0);

        // Freeze: branch at 0x40 held in EX for three mem_stall cycles
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        step();
        check("frz_setup_pc", ex_pc, 32'h40);
        drive(1'b1, 5'd3, 5'd4, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h44);
        ex_flush  = 1'b1;
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("frz_pc_write", 32'(pc_write), 32'd0);
            check("frz_ifid_write", 32'(ifid_write), 32'd0);
            step();
            check("frz_ex_pc", ex_pc, 32'h40);
            check("frz_ex_branch", 32'(ex_branch), 32'd1);
        end
        mem_stall = 1'b0;
        #1;
        check("frz_release_pc_write", 32'(pc_write), 32'd1);
        step();
        ex_flush = 1'b0;
        check("frz_flush_valid", 32'(ex_valid), 32'd0);
        check("frz_flush_pc", ex_pc, 32'd0);

        // Invalid decode slot: controls zeroed, fields still captured
        drive(1'b0, 5'd1, 5'd2, 5'd13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h50);
        step();
        check("inv_valid", 32'(ex_valid), 32'd0);
        check("inv_regwrite", 32'(ex_regwrite), 32'd0);
        check("inv_memread", 32'(ex_memread), 32'd0);
        check("inv_branch", 32'(ex_branch), 32'd0);
        check("inv_aluop", 32'(ex_aluop), 32'd0);
        check("inv_pc", ex_pc, 32'h50);

`ifdef HAZARD_PERF_CNT_EN
        check("perf_bubbles", perf_bubbles, 32'd3);
        check("perf_freeze", perf_freeze, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, bubble insertion, branch flush and memory-stall hold.
- Sits between decode and execute; registered ex_* outputs feed the ALU and the forwarding unit's ID/EX inputs (RegWrite, Rd, Rs1, Rs2).
- Drives pc_write / ifid_write back to fetch.

Parameters:
XLEN, 32, datapath width of operand, immediate and PC fields
ALUOP_W, 4, width of ALU operation code

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_uses_rs1, id_uses_rs2  in  1 each  instruction reads rs1 / rs2
id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch  in  1 each  decoded controls
id_aluop  in  ALUOP_W  ALU op
id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN each  operands, immediate, PC
ex_flush  in  1  taken branch/jump resolved in EX; kill younger instruction
mem_stall  in  1  data memory busy; freeze pipeline
ex_valid  out  1  EX slot holds a real instruction
ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch  out  1 each  registered controls
ex_aluop  out  ALUOP_W  registered ALU op
ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  XLEN each  registered datapath
load_use_stall  out  1  combinational hazard indication
pc_write, ifid_write  out  1 each  fetch/IF-ID enables (1 = advance)

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0. pc_write and ifid_write follow the combinational equations below, so both are 1 when no stall is active.
- Hazard (combinational on current registers):
  - load_use_stall = id_valid & ex_valid & ex_memread & (ex_rd!=0) & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- Per rising clk, priority order:
  1. mem_stall=1: all ex_* registers hold. pc_write=0, ifid_write=0. ex_flush and load_use_stall are ignored this cycle; the branch remains in EX, so the flush is re-presented.
  2. ex_flush=1: bubble loaded. ex_valid=0 and all ex_* controls 0; ex_rd/ex_rs1/ex_rs2 are forced to 0. pc_write=1, ifid_write=1 (fetch redirect is handled upstream).
  3. load_use_stall=1: bubble loaded (same as flush). pc_write=0, ifid_write=0 for exactly one cycle; the next cycle re-evaluates with the bubble in EX.
  4. Otherwise: all id_* fields captured, ex_valid=id_valid. If id_valid=0, controls are zeroed regardless of id_* control inputs.
- Bubble invariant: ex_regwrite=ex_memread=ex_memwrite=0 whenever ex_valid=0, so the forwarding unit never forwards from a bubble.
- Latency: one cycle from id_* to ex_*.
- Back-to-back load-use across two consumers: each dependent instruction stalls independently; at most one bubble per load.
- rd=0 load never stalls.
- Reset mid-stall: registers clear immediately; stall deasserts once the register contents are zero.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs perf_bubbles[31:0] and perf_freeze[31:0], both reset to 0.
  - perf_bubbles increments on each flush or load-use bubble insertion that is not masked by mem_stall.
  - perf_freeze increments on each mem_stall cycle.
  - Both counters saturate at all ones.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with ex_regwrite=1 -> all ex_* outputs 0 immediately (asynchronous), pc_write=1.
- Load-use: lw x5 in EX (ex_memread=1, ex_rd=5), ID add with id_rs2=5, id_uses_rs2=1 -> load_use_stall=1, pc_write=ifid_write=0. Next cycle ex_valid=0, ex_regwrite=0. Following cycle the add enters EX.
- No false stall: same load with id_rs2=5 but id_uses_rs2=0, and a second case with load ex_rd=0 -> load_use_stall=0, instruction captured.
- Flush vs hazard: ex_flush=1 and load_use_stall=1 in the same cycle -> bubble loaded, pc_write=1, ifid_write=1.
- Freeze: mem_stall=1 for 3 cycles with ex_pc=0x40 and ex_flush=1 -> ex_pc stays 0x40, pc_write=0. After release, the flush takes effect on the next edge.
- Normal flow: 4 independent instructions with id_pc 0x0,0x4,0x8,0xC -> ex_pc follows one cycle later, ex_valid=1, no stalls.
